ped_expander: RTL and testbench

PED_EXPANDER -- requirements
Module: ped_expander

---
 rtl/ped_expander.sv | 250 +++++++++++++++++++++++++
 tb/tb_ped_expander.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_expander.sv
// Child expander: one parent per cycle into four child PEDs (codes 10,11,01,00).
// Define PED_EXPANDER_SORT_EN to add a stage ordering each beat's lanes by ascending PED.
module ped_expander #(
    parameter int unsigned WL      = 16,
    parameter int unsigned FWL     = 12,
    parameter int unsigned ERR_WL  = 20,
    parameter int unsigned ERR_FWL = 12,
    parameter int unsigned NLAYER  = 2,
    parameter int unsigned K       = 4,
    localparam int unsigned PW     = (K > 1) ? $clog2(K) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic [NLAYER*WL-1:0]      r_row,
    input  logic [WL-1:0]             y,
    input  logic [K*(NLAYER-1)*2-1:0] path_in,
    input  logic [K*ERR_WL-1:0]       ped_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NLAYER*2-1:0]     out_path,
    output logic [4*ERR_WL-1:0]       out_ped,
    output logic [PW-1:0]             out_parent,
    output logic                      out_last,
    output logic                      busy
);
    localparam int unsigned PLW = (NLAYER - 1) * 2;
    localparam int unsigned OPW = NLAYER * 2;
    localparam int unsigned AW  = 48;
    localparam logic [PW-1:0] LAST_P = PW'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic signed [AW-1:0] sym(input logic [1:0] c);
        case (c)
            2'b10:   return -48'sd3886;
            2'b11:   return -48'sd1295;
            2'b01:   return 48'sd1295;
            default: return 48'sd3886;
        endcase
    endfunction

    function automatic logic [1:0] lane_code(input int unsigned j);
        case (j)
            0:       return 2'b10;
            1:       return 2'b11;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    state_t                    state_q;
    logic [PW-1:0]             cnt_q;
    logic                      mode_q;
    logic [NLAYER*WL-1:0]      r_q;
    logic [WL-1:0]             y_q;
    logic [K*PLW-1:0]          path_q;
    logic [K*ERR_WL-1:0]       ped_q;
    logic                      in_ready_q, busy_q;
    logic                      s1_valid_q, s1_last_q;
    logic [PW-1:0]             s1_parent_q;
    logic [3:0][ERR_WL-1:0]    s1_err_q;
    logic                      out_valid_q, out_last_q;
    logic [PW-1:0]             out_parent_q;
    logic [3:0][OPW-1:0]       out_path_q;
    logic [3:0][ERR_WL-1:0]    out_ped_q;

    logic                      stall_c;
    logic [3:0][ERR_WL-1:0]    err_c, ped_c;
    logic [3:0][OPW-1:0]       path_c;
    logic                      fin_valid_c, fin_last_c;
    logic [PW-1:0]             fin_parent_c;
    logic [3:0][ERR_WL-1:0]    fin_ped_c;
    logic [3:0][OPW-1:0]       fin_path_c;

    assign stall_c = out_valid_q & ~out_ready;

    // Stage 1: residual error per child, interference terms truncated individually
    always_comb begin : stage1
        logic signed [AW-1:0] acc, r_i, prod;
        acc   = '0;
        r_i   = '0;
        prod  = '0;
        err_c = '0;
        for (int unsigned i = 1; i < NLAYER; i++) begin
            r_i  = AW'(signed'(r_q[i*WL +: WL]));
            prod = r_i * sym(path_q[32'(cnt_q)*PLW + (i-1)*2 +: 2]);
            acc  = acc + (prod >>> FWL);
        end
        for (int unsigned j = 0; j < 4; j++) begin
            prod     = AW'(signed'(r_q[0 +: WL])) * sym(lane_code(j));
            err_c[j] = ERR_WL'(AW'(signed'(y_q)) - (prod >>> FWL) - acc);
        end
    end

    // Stage 2: squared error plus parent PED, saturating; QPSK masks outer lanes
    always_comb begin : stage2
        logic signed [AW-1:0] e, sq;
        logic [AW-1:0]        tot;
        logic [PLW-1:0]       ppath;
        e      = '0;
        sq     = '0;
        tot    = '0;
        ped_c  = '0;
        path_c = '0;
        ppath  = path_q[32'(s1_parent_q)*PLW +: PLW];
        for (int unsigned j = 0; j < 4; j++) begin
            e   = AW'(signed'(s1_err_q[j]));
            sq  = e * e;
            tot = unsigned'(sq >>> ERR_FWL) + AW'(ped_q[32'(s1_parent_q)*ERR_WL +: ERR_WL]);
            ped_c[j] = (|tot[AW-1:ERR_WL]) ? '1 : tot[ERR_WL-1:0];
            if (mode_q && (j == 0 || j == 3)) begin
                ped_c[j] = '1;
            end
            path_c[j] = {ppath, lane_code(j)};
        end
    end

`ifdef PED_EXPANDER_SORT_EN
    logic                      s2_valid_q, s2_last_q;
    logic [PW-1:0]             s2_parent_q;
    logic [3:0][ERR_WL-1:0]    s2_ped_q, srt_ped_c;
    logic [3:0][OPW-1:0]       s2_path_q, srt_path_c;

    // Stable rank sort: each lane's slot is the number of lanes that must precede it
    always_comb begin : sort_net
        logic [1:0] rank;
        rank       = '0;
        srt_ped_c  = '0;
        srt_path_c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rank = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                if ((s2_ped_q[j] < s2_ped_q[i]) || ((s2_ped_q[j] == s2_ped_q[i]) && (j < i))) begin
                    rank = rank + 2'd1;
                end
            end
            srt_ped_c[rank]  = s2_ped_q[i];
            srt_path_c[rank] = s2_path_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_parent_q <= '0;
            s2_ped_q    <= '0;
            s2_path_q   <= '0;
        end else if (!stall_c) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                s2_parent_q <= s1_parent_q;
                s2_ped_q    <= ped_c;
                s2_path_q   <= path_c;
            end
        end
    end

    assign fin_valid_c  = s2_valid_q;
    assign fin_last_c   = s2_last_q;
    assign fin_parent_c = s2_parent_q;
    assign fin_ped_c    = srt_ped_c;
    assign fin_path_c   = srt_path_c;
`else
    assign fin_valid_c  = s1_valid_q;
    assign fin_last_c   = s1_last_q;
    assign fin_parent_c = s1_parent_q;
    assign fin_ped_c    = ped_c;
    assign fin_path_c   = path_c;
`endif

    // Job FSM, parent issue and pipeline registers; a stalled output freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            r_q          <= '0;
            y_q          <= '0;
            path_q       <= '0;
            ped_q        <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_parent_q  <= '0;
            s1_err_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_parent_q <= '0;
            out_path_q   <= '0;
            out_ped_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mode_q     <= mode;
                    r_q        <= r_row;
                    y_q        <= y;
                    path_q     <= path_in;
                    ped_q      <= ped_in;
                    cnt_q      <= '0;
                    state_q    <= RUN;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: if (!stall_c) begin
                    if (cnt_q == LAST_P) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
                DRAIN: if (out_valid_q && out_ready && out_last_q) begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            if (!stall_c) begin
                s1_valid_q  <= (state_q == RUN);
                s1_last_q   <= (cnt_q == LAST_P);
                s1_parent_q <= cnt_q;
                s1_err_q    <= err_c;
                out_valid_q <= fin_valid_c;
                out_last_q  <= fin_valid_c & fin_last_c;
                if (fin_valid_c) begin
                    out_parent_q <= fin_parent_c;
                    out_path_q   <= fin_path_c;
                    out_ped_q    <= fin_ped_c;
                end
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_parent = out_parent_q;
    assign out_path   = out_path_q;
    assign out_ped    = out_ped_q;

endmodule

// File: tb/tb_ped_expander.sv
// Bench for ped_expander: a K=1 instance fed from a vector table, a K=4 instance checked by scoreboard.
`timescale 1ns/1ps
module tb_ped_expander;
`ifdef PED_EXPANDER_SORT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int unsigned parent;
        bit          last;
        logic [15:0] path;
        logic [79:0] ped;
    } beat_t;

    typedef struct {
        bit          mode;
        logic [15:0] r0, r1, y;
        logic [1:0]  pc;
        logic [19:0] pin;
        logic [79:0] exp;
    } vec_t;

    typedef struct {
        bit          mode;
        logic [15:0] r0, r1, y;
        logic [7:0]  path;
        logic [79:0] ped;
    } job_t;

    logic clk, rst;
    logic a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [31:0] a_r_row;
    logic [15:0] a_y, a_out_path;
    logic [1:0]  a_path_in;
    logic [19:0] a_ped_in;
    logic [79:0] a_out_ped;
    logic [0:0]  a_out_parent;
    logic b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [31:0] b_r_row;
    logic [15:0] b_y, b_out_path;
    logic [7:0]  b_path_in;
    logic [79:0] b_ped_in, b_out_ped;
    logic [1:0]  b_out_parent;

    int nchecks = 0;
    int nerrors = 0;
    beat_t qa[$];
    beat_t qb[$];

    ped_expander #(.K(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
        .r_row(a_r_row), .y(a_y), .path_in(a_path_in), .ped_in(a_ped_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_path(a_out_path), .out_ped(a_out_ped),
        .out_parent(a_out_parent), .out_last(a_out_last), .busy(a_busy));

    ped_expander #(.K(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
        .r_row(b_r_row), .y(b_y), .path_in(b_path_in), .ped_in(b_ped_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_path(b_out_path), .out_ped(b_out_ped),
        .out_parent(b_out_parent), .out_last(b_out_last), .busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic longint sym(input logic [1:0] c);
        case (c)
            2'b10:   return -3886;
            2'b11:   return -1295;
            2'b01:   return 1295;
            default: return 3886;
        endcase
    endfunction

    function automatic logic [1:0] lane_code(input int j);
        case (j)
            0:       return 2'b10;
            1:       return 2'b11;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Reference arithmetic for one parent, NLAYER=2
    function automatic logic [79:0] model_peds(input bit mode, input logic [15:0] r0, input logic [15:0] r1,
                                               input logic [15:0] y, input logic [1:0] pc, input logic [19:0] pin);
        longint rr0, rr1, yy, t, e, tot;
        logic [19:0] e20;
        logic [79:0] res;
        rr0 = longint'($signed(r0));
        rr1 = longint'($signed(r1));
        yy  = longint'($signed(y));
        t   = (rr1 * sym(pc)) >>> 12;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            e   = yy - ((rr0 * sym(lane_code(j))) >>> 12) - t;
            e20 = e[19:0];
            e   = longint'($signed(e20));
            tot = ((e * e) >>> 12) + longint'(pin);
            if (tot > 1048575) tot = 1048575;
            if (mode && (j == 0 || j == 3)) tot = 1048575;
            res[j*20 +: 20] = tot[19:0];
        end
        return res;
    endfunction

    function automatic beat_t make_beat(input logic [79:0] peds, input logic [1:0] pc,
                                        input int unsigned parent, input bit last);
        beat_t b;
        logic [19:0] pv [4];
        logic [3:0]  pa [4];
        logic [19:0] tv;
        logic [3:0]  ta;
        for (int j = 0; j < 4; j++) begin
            pv[j] = peds[j*20 +: 20];
            pa[j] = {pc, lane_code(j)};
        end
`ifdef PED_EXPANDER_SORT_EN
        for (int i = 1; i < 4; i++) begin
            for (int k = i; k > 0 && pv[k-1] > pv[k]; k--) begin
                tv = pv[k]; pv[k] = pv[k-1]; pv[k-1] = tv;
                ta = pa[k]; pa[k] = pa[k-1]; pa[k-1] = ta;
            end
        end
`else
        tv = '0;
        ta = '0;
`endif
        for (int j = 0; j < 4; j++) begin
            b.path[j*4 +: 4]  = pa[j];
            b.ped[j*20 +: 20] = pv[j];
        end
        b.parent = parent;
        b.last   = last;
        return b;
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.mode = ($urandom_range(0, 3) == 0);
        j.r0   = 16'($urandom_range(0, 16383)) - 16'd8192;
        j.r1   = 16'($urandom_range(0, 16383)) - 16'd8192;
        j.y    = 16'($urandom);
        j.path = 8'($urandom);
        for (int p = 0; p < 4; p++)
            j.ped[p*20 +: 20] = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1040000, 1048575))
                                                             : 20'($urandom_range(0, 5000));
        return j;
    endfunction

    // Scoreboard monitors: beats are compared on the falling edge before their handshake edge
    always @(negedge clk) begin : mon_a
        beat_t e;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                nchecks++; nerrors++;
                $display("FAIL a_unexpected_beat: got parent %0d expected none", a_out_parent);
            end else begin
                e = qa.pop_front();
                check("a_beat", {a_out_parent, a_out_last, a_out_path, a_out_ped},
                      {1'(e.parent), e.last, e.path, e.ped});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                nchecks++; nerrors++;
                $display("FAIL b_unexpected_beat: got parent %0d expected none", b_out_parent);
            end else begin
                e = qb.pop_front();
                check("b_beat", {b_out_parent, b_out_last, b_out_path, b_out_ped},
                      {2'(e.parent), e.last, e.path, e.ped});
            end
        end
    end

    task automatic send_a(input vec_t v);
        bit acc = 0;
        a_mode = v.mode; a_r_row = {v.r1, v.r0}; a_y = v.y; a_path_in = v.pc; a_ped_in = v.pin;
        a_in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk); acc = a_in_ready;
            @(posedge clk); #1;
        end
        check("a_accept", acc, 1);
        a_in_valid = 1'b0;
        qa.push_back(make_beat(v.exp, v.pc, 0, 1'b1));
        a_mode = 1'($urandom); a_r_row = $urandom; a_y = 16'($urandom); a_ped_in = 20'($urandom);
    endtask

    task automatic send_b(input job_t j);
        bit acc = 0;
        b_mode = j.mode; b_r_row = {j.r1, j.r0}; b_y = j.y; b_path_in = j.path; b_ped_in = j.ped;
        b_in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk); acc = b_in_ready;
            @(posedge clk); #1;
        end
        check("b_accept", acc, 1);
        b_in_valid = 1'b0;
        for (int p = 0; p < 4; p++)
            qb.push_back(make_beat(model_peds(j.mode, j.r0, j.r1, j.y, j.path[p*2 +: 2], j.ped[p*20 +: 20]),
                                   j.path[p*2 +: 2], p, p == 3));
        b_mode = 1'($urandom); b_r_row = $urandom; b_y = 16'($urandom);
        b_path_in = 8'($urandom); b_ped_in = {$urandom, $urandom, 16'($urandom)};
    endtask

    task automatic drain_a();
        for (int c = 0; c < 100 && qa.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("a_drain_left", qa.size(), 0);
        check("a_idle_after", {a_in_ready, a_busy}, 2'b10);
    endtask

    task automatic drain_b(input bit rand_ready);
        for (int c = 0; c < 300 && qb.size() != 0; c++) begin
            @(posedge clk); #1;
            if (rand_ready) b_out_ready = ($urandom_range(0, 3) != 0);
        end
        b_out_ready = 1'b1;
        check("b_drain_left", qb.size(), 0);
        check("b_idle_after", {b_in_ready, b_busy}, 2'b10);
    endtask

    initial begin : main
        vec_t tbl [6];
        job_t jb;
        int n;
        bit hit;
        logic [98:0] snap;

        tbl[0] = '{1'b0, 16'd4096, 16'd0,     16'd0,    2'b00, 20'd0,       {20'd3686, 20'd409, 20'd409, 20'd3686}};
        tbl[1] = '{1'b0, 16'd4096, 16'd0,     16'd1295, 2'b00, 20'd0,       {20'd1638, 20'd0, 20'd1637, 20'd6553}};
        tbl[2] = '{1'b0, 16'd4096, 16'd0,     16'd0,    2'b00, 20'd1048575, {4{20'd1048575}}};
        tbl[3] = '{1'b1, 16'd4096, 16'd0,     16'd0,    2'b00, 20'd0,       {20'd1048575, 20'd409, 20'd409, 20'd1048575}};
        tbl[4] = '{1'b0, 16'd4096, 16'd2048,  16'd0,    2'b01, 20'd100,     {20'd5116, 20'd1020, 20'd202, 20'd2661}};
        tbl[5] = '{1'b0, 16'd4096, 16'hF800,  16'd0,    2'b01, 20'd0,       {20'd2559, 20'd102, 20'd921, 20'd5018}};

        rst = 1'b0;
        a_in_valid = 0; a_mode = 0; a_r_row = 0; a_y = 0; a_path_in = 0; a_ped_in = 0; a_out_ready = 1;
        b_in_valid = 0; b_mode = 0; b_r_row = 0; b_y = 0; b_path_in = 0; b_ped_in = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_state", {a_in_ready, a_out_valid, a_out_last, a_busy, a_out_parent, a_out_path, a_out_ped},
              {4'b1000, 97'd0});
        check("b_reset_state", {b_in_ready, b_out_valid, b_out_last, b_busy, b_out_parent, b_out_path, b_out_ped},
              {4'b1000, 98'd0});
        rst = 1'b1;
        @(posedge clk); #1;

        // K=1 vector table
        for (int i = 0; i < 6; i++) begin
            send_a(tbl[i]);
            drain_a();
        end

        // Latency from accept edge to first valid beat
        jb = rand_job();
        send_b(jb);
        check("b_busy_in_job", {b_in_ready, b_busy}, 2'b01);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!b_out_valid && n < 20);
        check("b_latency", n - 1, LAT);
        drain_b(1'b0);

        // Saturation on every parent
        jb = rand_job();
        jb.ped = {4{20'd1048575}};
        send_b(jb);
        drain_b(1'b0);

        // Mid-job stall for 5 cycles, then in_ready timing around the last handshake
        jb = rand_job();
        send_b(jb);
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            hit = b_out_valid && (b_out_parent == 2'd1);
        end
        check("b_stall_reach", hit, 1);
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        snap = {b_out_valid, b_out_parent, b_out_path, b_out_ped};
        check("b_stall_parent", {b_out_valid, b_out_parent}, 3'b110);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("b_stall_hold", {b_out_valid, b_out_parent, b_out_path, b_out_ped}, snap);
        end
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            hit = b_out_valid && b_out_last;
        end
        check("b_last_seen", hit, 1);
        check("b_ready_before_last_hs", b_in_ready, 0);
        @(posedge clk); #1;
        check("b_ready_after_last_hs", b_in_ready, 1);
        check("b_stall_left", qb.size(), 0);

        // Reset in the middle of a job
        jb = rand_job();
        send_b(jb);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("b_midreset_state", {b_out_valid, b_in_ready, b_busy, b_out_ped}, {3'b010, 80'd0});
        qb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        jb = rand_job();
        send_b(jb);
        drain_b(1'b1);

        // Random jobs with random backpressure
        for (int i = 0; i < 8; i++) begin
            jb = rand_job();
            send_b(jb);
            drain_b(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
